// File: rtl/tick_generator.sv
// Multi-channel timebase: a shared prescaler produces the base tick, and NCH
// channel dividers turn it into per-channel tick pulses and square waves.
module tick_generator #(
  parameter int unsigned CLK_HZ      = 100_000_000,
  parameter int unsigned BASE_HZ     = 1000,
  parameter int unsigned NCH         = 4,
  parameter int unsigned DW          = 16,
  parameter int unsigned DEFAULT_DIV = 500
) (
  input  logic                                          clk,
  input  logic                                          Sync_Reset,
  input  logic                                          en,
  input  logic                                          clr,
  input  logic                                          cfg_we,
  input  logic [((NCH > 1) ? $clog2(NCH) : 1)-1:0]      cfg_ch,
  input  logic [DW-1:0]                                 cfg_div,
  output logic                                          base_tick,
  output logic [NCH-1:0]                                tick,
  output logic [NCH-1:0]                                sq,
  output logic [NCH-1:0]                                pending
);

  localparam int unsigned PRE = CLK_HZ / BASE_HZ;
  localparam int unsigned PW  = (PRE > 1) ? $clog2(PRE) : 1;
  localparam int unsigned CW  = (NCH > 1) ? $clog2(NCH) : 1;

  if ((CLK_HZ % BASE_HZ) != 0 || PRE < 2) begin : g_bad_pre
    $fatal(1, "tick_generator: CLK_HZ must be a multiple of BASE_HZ with a ratio of at least 2");
  end
  if (DW < 32 && 64'(DEFAULT_DIV) >= (64'd1 << DW)) begin : g_bad_div
    $fatal(1, "tick_generator: DEFAULT_DIV does not fit in DW bits");
  end

  logic [PW-1:0]  pcnt_q, pcnt_d;
  logic           base_tick_q, base_tick_d;
  logic [DW-1:0]  ccnt_q [NCH];
  logic [DW-1:0]  ccnt_d [NCH];
  logic [DW-1:0]  adiv_q [NCH];
  logic [DW-1:0]  adiv_d [NCH];
  logic [DW-1:0]  sdiv_q [NCH];
  logic [DW-1:0]  sdiv_d [NCH];
  logic [NCH-1:0] pend_q, pend_d;
  logic [NCH-1:0] tick_q, tick_d;
  logic [NCH-1:0] sq_q, sq_d;
  logic [NCH-1:0] hit;
  logic           wrap;

  // clr takes precedence, so a clear cycle never counts as a wrap
  assign wrap = en && !clr && (pcnt_q == PW'(PRE - 1));

  always_comb begin
    hit = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      hit[i] = cfg_we && (cfg_ch == CW'(i));
    end
  end

  always_comb begin
    pcnt_d      = pcnt_q;
    base_tick_d = wrap;
    if (clr) begin
      pcnt_d = '0;
    end else if (en) begin
      pcnt_d = wrap ? '0 : pcnt_q + PW'(1);
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < NCH; i++) begin
      ccnt_d[i] = ccnt_q[i];
      adiv_d[i] = adiv_q[i];
      sdiv_d[i] = sdiv_q[i];
      pend_d[i] = pend_q[i];
      tick_d[i] = 1'b0;
      sq_d[i]   = sq_q[i];
      if (clr) begin
        ccnt_d[i] = '0;
        sq_d[i]   = 1'b1;
        pend_d[i] = 1'b0;
        if (pend_q[i]) begin
          adiv_d[i] = sdiv_q[i];
        end
        if (hit[i]) begin
          adiv_d[i] = cfg_div;
          sdiv_d[i] = cfg_div;
        end
      end else begin
        if (wrap && adiv_q[i] != '0) begin
          if (ccnt_q[i] == adiv_q[i] - DW'(1)) begin
            ccnt_d[i] = '0;
            tick_d[i] = 1'b1;
            sq_d[i]   = ~sq_q[i];
            if (pend_q[i]) begin
              adiv_d[i] = sdiv_q[i];
              pend_d[i] = 1'b0;
            end
          end else begin
            ccnt_d[i] = ccnt_q[i] + DW'(1);
          end
        end
        // Decision uses the divisor active before this edge; a write landing on
        // the applying wrap re-arms the shadow for the following period.
        if (hit[i]) begin
          if (adiv_q[i] != '0) begin
            sdiv_d[i] = cfg_div;
            pend_d[i] = 1'b1;
          end else begin
            adiv_d[i] = cfg_div;
            ccnt_d[i] = '0;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge Sync_Reset) begin
    if (Sync_Reset) begin
      pcnt_q      <= '0;
      base_tick_q <= 1'b0;
      pend_q      <= '0;
      tick_q      <= '0;
      sq_q        <= '1;
      for (int unsigned i = 0; i < NCH; i++) begin
        ccnt_q[i] <= '0;
        adiv_q[i] <= DW'(DEFAULT_DIV);
        sdiv_q[i] <= DW'(DEFAULT_DIV);
      end
    end else begin
      pcnt_q      <= pcnt_d;
      base_tick_q <= base_tick_d;
      pend_q      <= pend_d;
      tick_q      <= tick_d;
      sq_q        <= sq_d;
      for (int unsigned i = 0; i < NCH; i++) begin
        ccnt_q[i] <= ccnt_d[i];
        adiv_q[i] <= adiv_d[i];
        sdiv_q[i] <= sdiv_d[i];
      end
    end
  end

  assign base_tick = base_tick_q;
  assign tick      = tick_q;
  assign sq        = sq_q;
  assign pending   = pend_q;

endmodule

// File: doc/tick_generator.md
# tick_generator

Parametrised multi-channel timebase for the traffic-light controller. A shared prescaler divides the system clock down to a base tick. NCH independent channel dividers count base ticks, and each channel produces a one-cycle tick pulse and a 50 % square wave. Each channel's divisor can be reprogrammed at run time through a glitch-free shadow load, and the block supports global pause and synchronous phase clear. It drives phase timers and lamp-blink logic.

## Interface
- CLK_HZ, 100_000_000, system clock frequency in Hz
- BASE_HZ, 1000, base tick rate; PRE = CLK_HZ/BASE_HZ
- NCH, 4, number of channels
- DW, 16, channel divisor width
- DEFAULT_DIV, 500, divisor loaded into every channel at reset (500 → 1 Hz square)
- clk  in  1  system clock, rising edge
- Sync_Reset  in  1  reset, asynchronous, active-high
- en  in  1  global run; low freezes the prescaler and all channels
- clr  in  1  synchronous clear/phase-align of all counters
- cfg_we  in  1  divisor write strobe
- cfg_ch  in  max(1,$clog2(NCH))  target channel of the write
- cfg_div  in  DW  new divisor; 0 means channel disabled
- base_tick  out  1  one-cycle pulse at BASE_HZ
- tick  out  NCH  per-channel one-cycle pulse every div base ticks
- sq  out  NCH  per-channel square wave, period 2·div base ticks
- pending  out  NCH  shadow divisor written but not yet active

## Operation
- Elaboration checks: CLK_HZ % BASE_HZ == 0 and PRE ≥ 2, else elaboration error. Also DEFAULT_DIV < 2^DW.
- Prescaler:
  - pcnt, width $clog2(PRE), counts 0..PRE-1 while en=1.
  - Internal strobe wrap = en && pcnt==PRE-1. On wrap, pcnt returns to 0.
- Channel i:
  - State: active divisor adiv[i], shadow sdiv[i], counter ccnt[i] (DW bits).
  - On wrap with adiv≠0:
    - If ccnt == adiv-1: ccnt←0, tick[i]←1, sq[i]←~sq[i], and if pending then adiv←sdiv, pending←0.
    - Otherwise ccnt←ccnt+1.
  - adiv==0 (disabled): ccnt held at 0, tick=0, sq holds its last value.
  - Divisor 1: tick on every base tick; sq toggles on every base tick.
- Config write (cfg_we=1, cfg_ch<NCH):
  - If adiv≠0: sdiv←cfg_div and pending←1. The new value applies at that channel's next wrap-around.
  - If adiv==0: adiv←cfg_div immediately, ccnt←0, pending stays 0.
  - Repeated writes before the wrap: last write wins.
  - cfg_ch ≥ NCH: write ignored.
- clr=1, which has priority over en and wrap:
  - pcnt←0 and all ccnt←0.
  - base_tick and tick←0; sq←all 1s.
  - Every pending shadow is copied into adiv; pending←0.
  - A cfg_we in the same cycle as clr is applied directly to adiv.
- en=0: pcnt, ccnt, sq, adiv are held. base_tick and tick are 0. Config writes are still accepted.
- Reset values (asynchronous, immediate on Sync_Reset, no clk edge needed):
  - pcnt=0, ccnt=0.
  - adiv=sdiv=DEFAULT_DIV, pending=0.
  - base_tick=0, tick=0, sq=all 1s.

## Timing
- All outputs are registered; nothing is combinational from inputs.
- base_tick is high for exactly one clk, in the cycle after the edge where wrap fired.
- With en held high after reset release, the first base_tick is high in cycle PRE, then every PRE cycles.
- tick[i] coincides with the base_tick cycle on which the channel wraps, so the first tick is at cycle PRE·adiv.
- sq[i] changes on the same edge that raises tick[i].
- pending[i] rises on the edge after cfg_we and falls on the edge that raises the applying tick[i].
- en low for N cycles delays every subsequent pulse by exactly N cycles; no pulse is lost or duplicated.
- Counter arithmetic is unsigned. ccnt never exceeds adiv-1 because a divisor change applies only at wrap-around or from zero.

## Test plan
Parameters for all scenarios: CLK_HZ=100, BASE_HZ=10 (PRE=10), NCH=2, DW=8, DEFAULT_DIV=3.
- Free run after reset, en=1 → base_tick at cycles 10, 20, 30…; tick[0] at 30, 60…; sq[0] 1→0 at cycle 30, →1 at 60; pending=0.
- Write div=1 to ch1 at cycle 35 → pending[1]=1 at 36; old period completes with a tick at 60, pending falls then; subsequent ticks at 70, 80.
- Write div=0 to ch0 → after the next wrap-around no tick[0] and sq[0] frozen. Then write div=2 → applied immediately with ccnt=0; tick[0] after 20 cycles.
- en low for 25 cycles starting at cycle 15 → no pulses; base_tick resumes at 45; tick[0] at 55; sq values unchanged while paused.
- clr with simultaneous cfg_we(ch0, 5) while ch1 has pending=1 → next cycle all counters 0, sq=2'b11, adiv0=5, ch1 shadow applied, pending=0; tick[0] 50 cycles later.
- Assert Sync_Reset mid-period between clock edges → outputs reach their reset values before the next edge; after release, timing matches the first scenario.
